delta_seq_ctrl: RTL and testbench

DELTA_SEQ_CTRL -- requirements
Module: delta_seq_ctrl

---
 rtl/delta_seq_ctrl.sv | 188 ++++++++++++++++++
 tb/tb_delta_seq_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/delta_seq_ctrl.sv
// Step sequencer for the delta-gate datapath: walks a fixed 13-step select schedule
// and captures the four gate deltas from o_dgate at their scheduled steps.
module delta_seq_ctrl #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned NSTEP = 13
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             hold,
    input  logic [WIDTH-1:0] o_dgate,
    output logic [1:0]       sel_in1,
    output logic [1:0]       sel_in2,
    output logic             sel_in3,
    output logic [1:0]       sel_in4,
    output logic [2:0]       sel_in5,
    output logic [1:0]       sel_x1_1,
    output logic             sel_x1_2,
    output logic [1:0]       sel_x2_2,
    output logic             sel_as_1,
    output logic [1:0]       sel_as_2,
    output logic             sel_addsub,
    output logic [1:0]       sel_temp,
    output logic             sel_state,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] d_ot,
    output logic [WIDTH-1:0] d_at,
    output logic [WIDTH-1:0] d_it,
    output logic [WIDTH-1:0] d_ft
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    typedef struct packed {
        logic [1:0] in1;
        logic [1:0] in2;
        logic       in3;
        logic [1:0] in4;
        logic [2:0] in5;
        logic [1:0] x1_1;
        logic       x1_2;
        logic [1:0] x2_2;
        logic       as_1;
        logic [1:0] as_2;
        logic       addsub;
        logic [1:0] temp;
    } sel_t;

    localparam logic [3:0] LastStp = 4'(NSTEP - 1);

    state_e           state_q, state_d;
    logic [3:0]       stp_q, stp_d;
    sel_t             sel_q, sel_d;
    logic             sel_state_q, sel_state_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [WIDTH-1:0] d_ot_q, d_ot_d, d_at_q, d_at_d, d_it_q, d_it_d, d_ft_q, d_ft_d;

    function automatic sel_t sel_row(input logic [3:0] s);
        sel_t r;
        r = '0;
        case (s)
            4'd0: r.in4 = 2'd1;
            4'd2: begin
                r.in1 = 2'd2; r.in2 = 2'd3; r.in4 = 2'd2; r.in5 = 3'd1;
                r.as_2 = 2'd3; r.addsub = 1'b1;
            end
            4'd3: begin
                r.in2 = 2'd2; r.in4 = 2'd2; r.in5 = 3'd4;
            end
            4'd4: begin
                r.x1_1 = 2'd1; r.x2_2 = 2'd2; r.temp = 2'd2;
            end
            4'd5: begin
                r.in3 = 1'b1; r.in4 = 2'd2; r.x2_2 = 2'd1; r.as_1 = 1'b1;
                r.as_2 = 2'd2; r.addsub = 1'b1; r.temp = 2'd1;
            end
            4'd6: begin
                r.in1 = 2'd1; r.in4 = 2'd2; r.in5 = 3'd2; r.x1_1 = 2'd2;
                r.as_2 = 2'd1; r.temp = 2'd2;
            end
            4'd7: begin
                r.in2 = 2'd1; r.in4 = 2'd2; r.in5 = 3'd3; r.x1_2 = 1'b1;
                r.x2_2 = 2'd2; r.temp = 2'd2;
            end
            4'd8: begin
                r.in1 = 2'd3; r.in4 = 2'd2; r.in5 = 3'd3; r.x1_1 = 2'd2;
                r.x2_2 = 2'd1; r.temp = 2'd2;
            end
            4'd9: begin
                r.x1_2 = 1'b1; r.temp = 2'd2;
            end
            4'd10, 4'd11, 4'd12: begin
                r.x2_2 = 2'd1; r.temp = 2'd2;
            end
            default: r = '0;
        endcase
        return r;
    endfunction

    always_comb begin
        state_d = state_q;
        stp_d   = stp_q;
        d_ot_d  = d_ot_q;
        d_at_d  = d_at_q;
        d_it_d  = d_it_q;
        d_ft_d  = d_ft_q;
        unique case (state_q)
            StIdle, StDone: begin
                stp_d   = 4'd0;
                state_d = start ? StRun : StIdle;
            end
            StRun: begin
                // A held cycle leaves step and captures untouched.
                if (!hold) begin
                    if (stp_q == 4'd7)  d_ot_d = o_dgate;
                    if (stp_q == 4'd9)  d_at_d = o_dgate;
                    if (stp_q == 4'd10) d_it_d = o_dgate;
                    if (stp_q == 4'd12) d_ft_d = o_dgate;
                    if (stp_q == LastStp) begin
                        state_d = StDone;
                        stp_d   = 4'd0;
                    end else begin
                        stp_d = stp_q + 4'd1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
                stp_d   = 4'd0;
            end
        endcase

        // Outputs are decoded from the next state so the registered copy tracks the live step.
        sel_d       = (state_d == StRun) ? sel_row(stp_d) : '0;
        sel_state_d = (state_d == StRun) && (stp_d >= 4'd7);
        busy_d      = (state_d == StRun);
        done_d      = (state_d == StDone);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= StIdle;
            stp_q       <= 4'd0;
            sel_q       <= '0;
            sel_state_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            d_ot_q      <= '0;
            d_at_q      <= '0;
            d_it_q      <= '0;
            d_ft_q      <= '0;
        end else begin
            state_q     <= state_d;
            stp_q       <= stp_d;
            sel_q       <= sel_d;
            sel_state_q <= sel_state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            d_ot_q      <= d_ot_d;
            d_at_q      <= d_at_d;
            d_it_q      <= d_it_d;
            d_ft_q      <= d_ft_d;
        end
    end

    assign sel_in1    = sel_q.in1;
    assign sel_in2    = sel_q.in2;
    assign sel_in3    = sel_q.in3;
    assign sel_in4    = sel_q.in4;
    assign sel_in5    = sel_q.in5;
    assign sel_x1_1   = sel_q.x1_1;
    assign sel_x1_2   = sel_q.x1_2;
    assign sel_x2_2   = sel_q.x2_2;
    assign sel_as_1   = sel_q.as_1;
    assign sel_as_2   = sel_q.as_2;
    assign sel_addsub = sel_q.addsub;
    assign sel_temp   = sel_q.temp;
    assign sel_state  = sel_state_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign d_ot       = d_ot_q;
    assign d_at       = d_at_q;
    assign d_it       = d_it_q;
    assign d_ft       = d_ft_q;

endmodule

// File: tb/tb_delta_seq_ctrl.sv
// Scoreboard bench for delta_seq_ctrl: a cycle model pushes expected outputs as each
// stimulus cycle is driven; they are popped and compared once the DUT has clocked.
module tb_delta_seq_ctrl;

    logic        clk, rst, start, hold;
    logic [31:0] o_dgate;
    logic [1:0]  sel_in1, sel_in2, sel_in4, sel_x1_1, sel_x2_2, sel_as_2, sel_temp;
    logic [2:0]  sel_in5;
    logic        sel_in3, sel_x1_2, sel_as_1, sel_addsub, sel_state, busy, done;
    logic [31:0] d_ot, d_at, d_it, d_ft;

    delta_seq_ctrl #(.WIDTH(32), .NSTEP(13)) dut (
        .clk(clk), .rst(rst), .start(start), .hold(hold), .o_dgate(o_dgate),
        .sel_in1(sel_in1), .sel_in2(sel_in2), .sel_in3(sel_in3), .sel_in4(sel_in4),
        .sel_in5(sel_in5), .sel_x1_1(sel_x1_1), .sel_x1_2(sel_x1_2), .sel_x2_2(sel_x2_2),
        .sel_as_1(sel_as_1), .sel_as_2(sel_as_2), .sel_addsub(sel_addsub),
        .sel_temp(sel_temp), .sel_state(sel_state), .busy(busy), .done(done),
        .d_ot(d_ot), .d_at(d_at), .d_it(d_it), .d_ft(d_ft)
    );

    always #5 clk = ~clk;

    logic [20:0]  dut_sel;
    logic [2:0]   dut_flg;
    logic [127:0] dut_dv;
    assign dut_sel = {sel_in1, sel_in2, sel_in3, sel_in4, sel_in5, sel_x1_1, sel_x1_2,
                      sel_x2_2, sel_as_1, sel_as_2, sel_addsub, sel_temp};
    assign dut_flg = {sel_state, busy, done};
    assign dut_dv  = {d_ot, d_at, d_it, d_ft};

    typedef struct packed {
        logic [20:0]  sel;
        logic [2:0]   flg;
        logic [127:0] dv;
    } exp_t;

    exp_t q[$];
    int n_chk = 0;
    int n_pass = 0;

    // Reference model: m_st 0 = idle, 1 = run, 2 = done.
    int          m_st = 0;
    int          m_stp = 0;
    logic [31:0] m_ot = 0, m_at = 0, m_it = 0, m_ft = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic logic [20:0] pk(input int a, b, c, d, e, f, g, h, i, j, k, l);
        return {2'(a), 2'(b), 1'(c), 2'(d), 3'(e), 2'(f), 1'(g), 2'(h), 1'(i), 2'(j),
                1'(k), 2'(l)};
    endfunction

    function automatic logic [20:0] row(input int s);
        case (s)
            0:  return pk(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
            1:  return pk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            2:  return pk(2, 3, 0, 2, 1, 0, 0, 0, 0, 3, 1, 0);
            3:  return pk(0, 2, 0, 2, 4, 0, 0, 0, 0, 0, 0, 0);
            4:  return pk(0, 0, 0, 0, 0, 1, 0, 2, 0, 0, 0, 2);
            5:  return pk(0, 0, 1, 2, 0, 0, 0, 1, 1, 2, 1, 1);
            6:  return pk(1, 0, 0, 2, 2, 2, 0, 0, 0, 1, 0, 2);
            7:  return pk(0, 1, 0, 2, 3, 0, 1, 2, 0, 0, 0, 2);
            8:  return pk(3, 0, 0, 2, 3, 2, 0, 1, 0, 0, 0, 2);
            9:  return pk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 2);
            default: return pk(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 2);
        endcase
    endfunction

    task automatic model_step(input logic s, input logic h, input logic [31:0] d);
        if (m_st == 1) begin
            if (!h) begin
                if (m_stp == 7)  m_ot = d;
                if (m_stp == 9)  m_at = d;
                if (m_stp == 10) m_it = d;
                if (m_stp == 12) m_ft = d;
                if (m_stp == 12) m_st = 2;
                else m_stp++;
            end
        end else if (s) begin
            m_st  = 1;
            m_stp = 0;
        end else begin
            m_st = 0;
        end
    endtask

    task automatic cyc(input logic s, input logic h, input logic [31:0] d);
        exp_t e;
        start   = s;
        hold    = h;
        o_dgate = d;
        model_step(s, h, d);
        e.sel = (m_st == 1) ? row(m_stp) : 21'd0;
        e.flg = {(m_st == 1) && (m_stp >= 7), m_st == 1, m_st == 2};
        e.dv  = {m_ot, m_at, m_it, m_ft};
        q.push_back(e);
        @(posedge clk);
        #1;
        e = q.pop_front();
        check_eq("sel", 128'(dut_sel), 128'(e.sel));
        check_eq("flags", 128'(dut_flg), 128'(e.flg));
        check_eq("deltas", dut_dv, e.dv);
    endtask

    // One sequence; hold held for hold_len cycles on the first cycle at hold_stp.
    task automatic run_seq(input int hold_stp, input int hold_len, input logic hold_on_start,
                           input int exp_lat);
        int          lat;
        int          held;
        logic        h;
        logic [31:0] d;
        lat  = -1;
        held = 0;
        for (int k = 1; k <= 40 && lat < 0; k++) begin
            if (k == 1) begin
                cyc(1'b1, hold_on_start, 32'h0);
            end else begin
                h = (m_st == 1) && (m_stp == hold_stp) && (held < hold_len);
                if (h) begin
                    held++;
                    d = 32'hAAAA;
                end else if (m_stp == hold_stp && hold_len > 0) begin
                    d = 32'h5555;
                end else begin
                    d = 32'h100 + 32'(m_stp);
                end
                cyc(1'b0, h, d);
            end
            if (done) lat = k;
        end
        check_eq("latency", 128'(lat), 128'(exp_lat));
        cyc(1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        int first_done;
        int second_done;
        clk     = 1'b0;
        rst     = 1'b1;
        start   = 1'b0;
        hold    = 1'b0;
        o_dgate = 32'h0;
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_sel", 128'(dut_sel), 128'd0);
        check_eq("rst_flags", 128'(dut_flg), 128'd0);
        check_eq("rst_deltas", dut_dv, 128'd0);
        rst = 1'b1;
        cyc(1'b0, 1'b0, 32'h0);

        // Plain sequence with stp-tagged data.
        run_seq(99, 0, 1'b0, 14);
        check_eq("d_ot", 128'(d_ot), 128'h107);
        check_eq("d_at", 128'(d_at), 128'h109);
        check_eq("d_it", 128'(d_it), 128'h10A);
        check_eq("d_ft", 128'(d_ft), 128'h10C);

        // Start with hold asserted in idle, then a 3-cycle stall at step 5.
        run_seq(5, 3, 1'b1, 17);
        check_eq("d_ot_hold5", 128'(d_ot), 128'h107);

        // Hold exactly on step 9: d_at comes from the released cycle.
        run_seq(9, 1, 1'b0, 15);
        check_eq("d_at_hold9", 128'(d_at), 128'h5555);
        check_eq("d_it_hold9", 128'(d_it), 128'h10A);

        // Start held high: back-to-back sequences.
        first_done  = -1;
        second_done = -1;
        for (int k = 1; k <= 28; k++) begin
            cyc(1'b1, 1'b0, (m_st == 1) ? 32'h200 + 32'(m_stp) : 32'h0);
            if (done && first_done < 0) first_done = k;
            else if (done) second_done = k;
        end
        check_eq("cont_done1", 128'(first_done), 128'd14);
        check_eq("cont_done2", 128'(second_done), 128'd28);
        cyc(1'b0, 1'b0, 32'h0);
        check_eq("cont_d_ft", 128'(d_ft), 128'h20C);

        // Reset mid-run at step 8.
        cyc(1'b1, 1'b0, 32'h0);
        for (int k = 0; k < 20 && !(m_st == 1 && m_stp == 8); k++)
            cyc(1'b0, 1'b0, 32'h300 + 32'(m_stp));
        check_eq("pre_rst_d_ot", 128'(d_ot), 128'h307);
        #2 rst = 1'b0;
        #1;
        check_eq("async_rst_sel", 128'(dut_sel), 128'd0);
        check_eq("async_rst_flags", 128'(dut_flg), 128'd0);
        check_eq("async_rst_deltas", dut_dv, 128'd0);
        m_st = 0; m_stp = 0; m_ot = 0; m_at = 0; m_it = 0; m_ft = 0;
        @(posedge clk);
        #1;
        rst = 1'b1;
        cyc(1'b0, 1'b0, 32'h0);
        run_seq(99, 0, 1'b0, 14);
        check_eq("post_rst_d_ot", 128'(d_ot), 128'h107);
        check_eq("post_rst_d_ft", 128'(d_ft), 128'h10C);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
